view_scroll_controller: RTL and testbench

- Sequences the camera (view window) over the world.
- Each frame it checks the doodle against the camera. When the doodle rises above half-screen, it scrolls the camera up by a quarter screen in per-frame steps. It then hands the platform generator a one-row spawn request through a req/ack handshake.
- It detects the doodle falling below the view and latches game-over.
- Sits between the physics block (doodle_y, frame_tick) and the renderer and platform generator.

---
 rtl/view_scroll_controller.sv | 142 ++++++++++++++
 tb/tb_view_scroll_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/view_scroll_controller.sv
// Camera sequencer: scrolls the view up when the doodle climbs past mid-screen,
// requests a new platform row after each scroll, and latches game-over on a fall.
module view_scroll_controller #(
   parameter int unsigned SCREEN_HEIGHT = 480,
   parameter int unsigned BLOCK_HEIGHT  = 16,
   parameter int unsigned SCROLL_DIST   = SCREEN_HEIGHT >> 2,
   parameter int unsigned SCROLL_STEP   = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_frame_tick,
   input  logic [31:0] i_doodle_y,
   input  logic        i_restart,
   input  logic        i_spawn_ack,
   output logic [31:0] o_camera_y,
   output logic        o_scrolling,
   output logic        o_new_view,
   output logic        o_spawn_req,
   output logic [31:0] o_spawn_y,
   output logic        o_game_over,
   output logic [15:0] o_view_count
);

   typedef enum logic [1:0] {StIdle, StScroll, StSpawn, StOver} state_e;

   localparam logic [31:0] HalfScreen = 32'(SCREEN_HEIGHT >> 1);
   localparam logic [32:0] ViewSpan   = 33'(SCROLL_DIST) + 33'(SCREEN_HEIGHT);
   localparam logic [32:0] MaxY       = 33'h0_FFFF_FFFF;
   localparam logic [31:0] SpawnOfs   = 32'(SCREEN_HEIGHT - BLOCK_HEIGHT);
   localparam logic [31:0] Dist       = 32'(SCROLL_DIST);
   localparam logic [31:0] Step       = 32'(SCROLL_STEP);

   state_e      r_state, w_state_d;
   logic [31:0] r_camera_y, w_camera_y_d;
   logic [31:0] r_remaining, w_remaining_d;
   logic [31:0] r_spawn_y, w_spawn_y_d;
   logic [15:0] r_view_count, w_view_count_d;
   logic        r_new_view, w_new_view_d;
   logic        r_scrolling, w_scrolling_d;
   logic        r_spawn_req, w_spawn_req_d;
   logic        r_game_over, w_game_over_d;

   logic [31:0] w_step;
   logic        w_fall, w_rise, w_room;

   always_comb begin
      w_fall = i_doodle_y < r_camera_y;
      // Subtraction only matters when no fall, so it never underflows in use.
      w_rise = !w_fall && ((i_doodle_y - r_camera_y) > HalfScreen);
      w_room = ({1'b0, r_camera_y} + ViewSpan) <= MaxY;
      w_step = (r_remaining < Step) ? r_remaining : Step;
   end

   always_comb begin
      w_state_d      = r_state;
      w_camera_y_d   = r_camera_y;
      w_remaining_d  = r_remaining;
      w_spawn_y_d    = r_spawn_y;
      w_view_count_d = r_view_count;
      w_new_view_d   = 1'b0;
      if (i_restart) begin
         w_state_d      = StIdle;
         w_camera_y_d   = '0;
         w_remaining_d  = '0;
         w_spawn_y_d    = '0;
         w_view_count_d = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_frame_tick) begin
                  if (w_fall) begin
                     w_state_d = StOver;
                  end else if (w_rise && w_room) begin
                     w_state_d     = StScroll;
                     w_remaining_d = Dist;
                     w_new_view_d  = 1'b1;
                  end
               end
            end
            StScroll: begin
               if (i_frame_tick) begin
                  if (w_fall) begin
                     w_state_d = StOver;
                  end else begin
                     w_camera_y_d  = r_camera_y + w_step;
                     w_remaining_d = r_remaining - w_step;
                     if (r_remaining == w_step) begin
                        w_state_d   = StSpawn;
                        w_spawn_y_d = r_camera_y + w_step + SpawnOfs;
                     end
                  end
               end
            end
            StSpawn: begin
               if (i_spawn_ack) begin
                  w_state_d      = StIdle;
                  w_view_count_d = r_view_count + 16'd1;
               end
            end
            StOver: begin
            end
            default: w_state_d = StIdle;
         endcase
      end
      w_scrolling_d = (w_state_d == StScroll);
      w_spawn_req_d = (w_state_d == StSpawn);
      w_game_over_d = (w_state_d == StOver);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_camera_y   <= '0;
         r_remaining  <= '0;
         r_spawn_y    <= '0;
         r_view_count <= '0;
         r_new_view   <= 1'b0;
         r_scrolling  <= 1'b0;
         r_spawn_req  <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_camera_y   <= w_camera_y_d;
         r_remaining  <= w_remaining_d;
         r_spawn_y    <= w_spawn_y_d;
         r_view_count <= w_view_count_d;
         r_new_view   <= w_new_view_d;
         r_scrolling  <= w_scrolling_d;
         r_spawn_req  <= w_spawn_req_d;
         r_game_over  <= w_game_over_d;
      end
   end

   assign o_camera_y   = r_camera_y;
   assign o_scrolling  = r_scrolling;
   assign o_new_view   = r_new_view;
   assign o_spawn_req  = r_spawn_req;
   assign o_spawn_y    = r_spawn_y;
   assign o_game_over  = r_game_over;
   assign o_view_count = r_view_count;

endmodule

// File: tb/tb_view_scroll_controller.sv
// Directed and randomized bench for view_scroll_controller; two instances
// (step 8 and step 50) are checked against a behavioural camera model.
module tb_view_scroll_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick, restart, spawn_ack;
   logic [31:0] doodle_y;

   logic [31:0] cam_a, sy_a, cam_b, sy_b;
   logic        sc_a, nv_a, sr_a, go_a, sc_b, nv_b, sr_b, go_b;
   logic [15:0] vc_a, vc_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   view_scroll_controller dut_a (
      .i_clk(clk), .i_reset(rst_n), .i_frame_tick(frame_tick), .i_doodle_y(doodle_y),
      .i_restart(restart), .i_spawn_ack(spawn_ack), .o_camera_y(cam_a), .o_scrolling(sc_a),
      .o_new_view(nv_a), .o_spawn_req(sr_a), .o_spawn_y(sy_a), .o_game_over(go_a),
      .o_view_count(vc_a)
   );

   view_scroll_controller #(.SCROLL_STEP(50)) dut_b (
      .i_clk(clk), .i_reset(rst_n), .i_frame_tick(frame_tick), .i_doodle_y(doodle_y),
      .i_restart(restart), .i_spawn_ack(spawn_ack), .o_camera_y(cam_b), .o_scrolling(sc_b),
      .o_new_view(nv_b), .o_spawn_req(sr_b), .o_spawn_y(sy_b), .o_game_over(go_b),
      .o_view_count(vc_b)
   );

   // Model phase: 0 idle, 1 scrolling, 2 awaiting spawn ack, 3 game over.
   typedef struct {
      int          ph;
      logic [31:0] cam;
      logic [31:0] left;
      logic [31:0] sy;
      logic [15:0] views;
      bit          nv;
   } mdl_t;

   mdl_t        m [2];
   int unsigned steps [2] = '{8, 50};

   function automatic mdl_t mdl_clear();
      mdl_t n;
      n.ph = 0; n.cam = 0; n.left = 0; n.sy = 0; n.views = 0; n.nv = 0;
      return n;
   endfunction

   function automatic mdl_t mdl_next(mdl_t c, int unsigned stp, bit ft, logic [31:0] dy,
                                     bit rs, bit ack);
      mdl_t        n = c;
      int unsigned adv;
      n.nv = 0;
      if (rs) return mdl_clear();
      if (c.ph == 0 && ft) begin
         if (dy < c.cam) n.ph = 3;
         else if (64'(dy) - 64'(c.cam) > 64'd240 && 64'(c.cam) + 64'd600 <= 64'hFFFF_FFFF) begin
            n.ph = 1; n.left = 120; n.nv = 1;
         end
      end else if (c.ph == 1 && ft) begin
         if (dy < c.cam) n.ph = 3;
         else begin
            adv    = (c.left < stp) ? c.left : stp;
            n.cam  = c.cam + adv;
            n.left = c.left - adv;
            if (n.left == 0) begin
               n.ph = 2;
               n.sy = n.cam + 480 - 16;
            end
         end
      end else if (c.ph == 2 && ack) begin
         n.ph    = 0;
         n.views = c.views + 1;
      end
      return n;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(int k, logic [31:0] cam, logic sc, logic nv, logic sr,
                          logic [31:0] sy, logic go, logic [15:0] vc);
      chk($sformatf("d%0d.camera_y", k), cam, m[k].cam);
      chk($sformatf("d%0d.scrolling", k), {31'd0, sc}, (m[k].ph == 1) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d.new_view", k), {31'd0, nv}, {31'd0, m[k].nv});
      chk($sformatf("d%0d.spawn_req", k), {31'd0, sr}, (m[k].ph == 2) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d.game_over", k), {31'd0, go}, (m[k].ph == 3) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d.view_count", k), {16'd0, vc}, {16'd0, m[k].views});
      if (m[k].ph == 2) chk($sformatf("d%0d.spawn_y", k), sy, m[k].sy);
   endtask

   task automatic check_all();
      chk_dut(0, cam_a, sc_a, nv_a, sr_a, sy_a, go_a, vc_a);
      chk_dut(1, cam_b, sc_b, nv_b, sr_b, sy_b, go_b, vc_b);
   endtask

   task automatic cyc(bit ft, logic [31:0] dy, bit rs, bit ack);
      frame_tick = ft; doodle_y = dy; restart = rs; spawn_ack = ack;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) m[k] = mdl_next(m[k], steps[k], ft, dy, rs, ack);
      check_all();
      frame_tick = 0; restart = 0; spawn_ack = 0;
   endtask

   // Pulse reset mid-cycle and check outputs before the next clock edge.
   task automatic async_reset();
      rst_n = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) m[k] = mdl_clear();
      check_all();
      chk("async.camera_y", cam_a, 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] dy;
      rst_n = 1'b0; frame_tick = 0; restart = 0; spawn_ack = 0; doodle_y = 0;
      for (int k = 0; k < 2; k++) m[k] = mdl_clear();
      #12;
      check_all();
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) cyc(1, 200, 0, 0);
      chk("idle.camera_y", cam_a, 32'd0);
      cyc(1, 240, 0, 0);
      chk("no_trig_240", {31'd0, sc_a}, 32'd0);
      cyc(1, 241, 0, 0);
      chk("trig.new_view", {31'd0, nv_a}, 32'd1);
      for (int i = 0; i < 15; i++) cyc(1, 1000, 0, 0);
      chk("scroll.camera_y", cam_a, 32'd120);
      chk("scroll.spawn_y", sy_a, 32'd584);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("ack.view_count", {16'd0, vc_a}, 32'd1);
      chk("ack.spawn_req", {31'd0, sr_a}, 32'd0);

      // Fall during a scroll, then ignore ticks/acks until restart.
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cyc(1, 300, 0, 0);
      chk("fall.pre_cam", cam_a, 32'd40);
      cyc(1, 30, 0, 0);
      chk("fall.game_over", {31'd0, go_a}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
      chk("over.camera_y", cam_a, 32'd40);
      cyc(0, 0, 1, 0);
      chk("restart.game_over", {31'd0, go_a}, 32'd0);

      // Ack held across the whole scroll: accepted on first spawn cycle.
      for (int i = 0; i < 16; i++) cyc(1, 300, 0, 1);
      chk("held_ack.spawn_req", {31'd0, sr_a}, 32'd1);
      cyc(0, 300, 0, 1);
      chk("held_ack.view_count", {16'd0, vc_a}, 32'd1);

      // Asynchronous reset mid-scroll and mid-spawn.
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 300, 0, 0);
      async_reset();
      for (int i = 0; i < 16; i++) cyc(1, 300, 0, 0);
      chk("spawn.req_before_reset", {31'd0, sr_a}, 32'd1);
      async_reset();

      // Restart beats a same-cycle ack.
      for (int i = 0; i < 16; i++) cyc(1, 300, 0, 0);
      cyc(0, 300, 1, 1);
      chk("restart_vs_ack.view_count", {16'd0, vc_a}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         dy = m[0].cam + $urandom_range(0, 380);
         if ($urandom_range(0, 15) == 0)
            dy = (m[0].cam >= 20) ? m[0].cam - $urandom_range(1, 20) : 32'd0;
         if ($urandom_range(0, 199) == 0) async_reset();
         else cyc($urandom_range(0, 1) == 1, dy, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
